// File: rtl/calc_pkg.sv
// Purpose: shared constants and types for the calculator datapath (multiplier product -> BCD display path).
// Latency: n/a, declarations only.
// Backpressure: n/a.
//
// Contents:
//   PRODUCT_W    - width of the multiplier product fed to the BCD converter
//   BCD_DIGITS   - decimal digits needed to show a full PRODUCT_W value
//   bcd_digit_t  - one packed BCD digit
//   b2b_state_e  - bin2bcd_seq controller states
//   bcd_ge5()    - double-dabble correction predicate
package calc_pkg;

  localparam int PRODUCT_W  = 32;
  localparam int BCD_DIGITS = 10;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_e;

  // A digit of 5 or more would become >= 10 after the next doubling, so it
  // needs the +3 correction before the shift.
  function automatic logic bcd_ge5(input bcd_digit_t d);
    return (d >= 4'd5);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Purpose: double-dabble digit correction, digit+3 when digit >= 5, else unchanged.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of the input digit).
//
// Ports:
//   dig_i - BCD digit before correction
//   dig_o - corrected digit, ready to be shifted left by one bit
module bcd_add3
  import calc_pkg::*;
(
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  always_comb begin
    dig_o = dig_i;
    if (bcd_ge5(dig_i)) begin
      dig_o = dig_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Latency: out_valid rises exactly IN_W cycles after the accepting edge.
// Backpressure: one conversion in flight; result held in DONE until out_ready, in_ready only in IDLE.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready - input handshake, in_bin sampled when both are high
//   in_bin            - unsigned binary value (normally the multiplier product)
//   out_valid/out_ready - output handshake, out_bcd is meaningful while out_valid
//   out_bcd           - packed BCD result, digit 0 in bits [3:0]; holds the last result
//   busy              - high while shifting
//   out_blank         - (only with BIN2BCD_BLANK_EN defined) leading-zero blanking mask,
//                       bit i set when digit i and all higher digits are zero; bit 0 never set
//
// Build option: define BIN2BCD_BLANK_EN to add the out_blank port and its register.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int IN_W = PRODUCT_W,
  parameter int NDIG = BCD_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic              busy
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [NDIG-1:0]   out_blank
`endif
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * NDIG;

  // Controller and datapath state
  b2b_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;       // shifts still to perform
  logic [IN_W-1:0]  bin_q;       // binary operand, consumed MSB first
  logic [BCD_W-1:0] bcd_q;       // BCD accumulator during the conversion
  logic [BCD_W-1:0] res_q;       // published result, independent of bcd_q
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // Next values of the {bcd, bin} shift chain for one SHIFT cycle
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_d;
  logic [IN_W-1:0]  bin_d;
  logic             last_shift;

  // Correct every digit first, then shift the whole chain left by one.
  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .dig_i (bcd_q[4*g +: 4]),
      .dig_o (bcd_adj[4*g +: 4])
    );
  end

  assign bcd_d      = {bcd_adj[BCD_W-2:0], bin_q[IN_W-1]};
  assign bin_d      = {bin_q[IN_W-2:0], 1'b0};
  assign last_shift = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            bin_q      <= in_bin;
            bcd_q      <= '0;
            cnt_q      <= CNT_W'(IN_W);
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // The final shift result goes straight into the output register,
          // so out_valid is up on the same edge that completes shift IN_W.
          if (last_shift) begin
            state_q     <= DONE;
            res_q       <= bcd_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        DONE: begin
          // Go through IDLE before taking new work; no accept on this edge.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = res_q;
  assign busy      = busy_q;

`ifdef BIN2BCD_BLANK_EN
  logic [NDIG-1:0] blank_d;
  logic [NDIG-1:0] blank_q;

  // Digit i is blank when the value above (and including) it is all zero.
  // Digit 0 always shows, so a zero result still displays "0".
  always_comb begin
    blank_d = '0;
    for (int i = 1; i < NDIG; i++) begin
      blank_d[i] = ((bcd_d >> (4 * i)) == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= ~NDIG'(1);
    end else if (state_q == SHIFT && last_shift) begin
      blank_q <= blank_d;
    end
  end

  assign out_blank = blank_q;
`endif

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
- REQ-001 The block SHALL have parameter IN_W, default 32: binary input width, matching the mult16 product width.
- REQ-002 The block SHALL have parameter NDIG, default 10: number of BCD output digits, with NDIG >= ceil(IN_W*log10(2)).
- REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all flops on the rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream presents an unsigned product on in_bin.
- REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a product.
- REQ-007 The block SHALL have port in_bin, input, IN_W bits: unsigned binary value, normally the multiplier product.
- REQ-008 The block SHALL have port out_valid, output, 1 bit: out_bcd holds a completed conversion.
- REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream (display driver) accepts the result.
- REQ-010 The block SHALL have port out_bcd, output, 4*NDIG bits: packed BCD digits, with digit 0 in bits [3:0].
- REQ-011 The block SHALL have port busy, output, 1 bit: high in SHIFT state.

Function
- REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, and SHALL use no other states.
- REQ-013 In IDLE, in_ready SHALL be 1; in all other states, in_ready SHALL be 0, so the block SHALL NOT overlap conversions.
- REQ-014 When in_valid & in_ready at an edge, the block SHALL load in_bin into the shift register, clear the BCD register to 0, set the counter to IN_W, and go to SHIFT.
- REQ-015 In SHIFT, each cycle SHALL first add 3 to every BCD digit >= 5, then shift {bcd, bin} left by one bit and decrement the counter.
- REQ-016 SHIFT SHALL perform exactly IN_W shifts, then enter DONE; out_valid SHALL therefore rise exactly IN_W cycles after the accepting edge.
- REQ-017 In DONE, out_valid SHALL be 1 and out_bcd SHALL hold stable for as long as out_ready is 0.
- REQ-018 On out_valid & out_ready, the block SHALL go to IDLE; in_ready SHALL assert on the following cycle, with no same-cycle accept.
- REQ-019 in_bin and in_valid SHALL be ignored outside IDLE.
- REQ-020 out_bcd SHALL retain its last result in IDLE and SHIFT; only out_valid qualifies it.
- REQ-021 An input of 0 and an input of 2^IN_W-1 SHALL both convert correctly with no overflow of the NDIG digits.

Reset
- REQ-022 rst SHALL asynchronously force state to IDLE, the counter to 0, and the shift and BCD registers to 0.
- REQ-023 Reset values SHALL be in_ready=1 (after deassertion), out_valid=0, busy=0, out_bcd=0.
- REQ-024 When rst asserts mid-SHIFT or in DONE, the block SHALL abort the conversion, discard the result, and produce no out_valid pulse.

Configuration
- REQ-025 When macro BIN2BCD_BLANK_EN is defined, the block SHALL add output port out_blank, NDIG bits: bit i = 1 when digit i and all higher digits are zero, except that bit 0 is always 0.
- REQ-026 out_blank SHALL be registered together with out_bcd, share its validity, and reset to all ones except bit 0.
- REQ-027 When BIN2BCD_BLANK_EN is undefined, the out_blank port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
- REQ-028 Shared package calc_pkg SHALL hold the PRODUCT_W=32 and BCD_DIGITS=10 constants, the bin2bcd state enum type, and the bcd digit typedef (4-bit).
- REQ-029 Sub-module bcd_add3 SHALL be combinational, taking one 4-bit digit and returning the digit+3 if >= 5, else the digit unchanged; the block SHALL instantiate it NDIG times.
- REQ-030 The counter SHALL be $clog2(IN_W+1) bits wide.

Verification
- REQ-031 in_bin=0 accepted -> after 32 cycles out_valid=1, out_bcd=all 0; with macro, out_blank=10'b1111111110.
- REQ-032 in_bin=32'd12345678 -> out_bcd digits 9..0 = 0,0,1,2,3,4,5,6,7,8, exactly 32 cycles after accept.
- REQ-033 in_bin=32'hFFFFFFFF -> digits 4,2,9,4,9,6,7,2,9,5; with macro, out_blank=0.
- REQ-034 Result ready, out_ready held 0 for 5 cycles -> out_valid and out_bcd stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- REQ-035 rst pulsed at shift 17 of a conversion of 99 -> out_valid never rises, out_bcd=0; the next conversion of 42 yields digits ...0,4,2 with blank=10'b1111111100.
- REQ-036 Back-to-back products 7, 8 with out_ready=1 held constantly -> two results, each 32 cycles after its own accept, separated by exactly the 1-cycle IDLE gap.
